// File: rtl/serial_sub_sequencer.sv
// Sequencer and result capture for the bit-serial subtractor: load, WIDTH shifts, done.
// Optional macro SERIAL_SUB_ABORT_EN adds an Abort input that cancels an operation.
module serial_sub_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             St,
`ifdef SERIAL_SUB_ABORT_EN
    input  logic             Abort,
`endif
    input  logic             SerialD,
    input  logic             BorrowIn,
    input  logic             XMsb,
    input  logic             YMsb,
    output logic             LE,
    output logic             ShiftE,
    output logic             BR,
    output logic             PoutE,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] BitCnt,
    output logic [WIDTH-1:0] Difference,
    output logic             Z,
    output logic             N,
    output logic             V
);

    // state | meaning
    // IDLE  | waiting for St
    // LOAD  | shift registers load, borrow flop cleared, operand MSBs latched
    // SHIFT | one difference bit per cycle, LSB first, WIDTH cycles
    // DONE  | result and flags valid, Done/PoutE pulse
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] diff_nxt;
    logic             x_msb, y_msb;
    logic             z_q, n_q, v_q;
    logic             abort_hit;
    logic             last_bit;

`ifdef SERIAL_SUB_ABORT_EN
    logic [WIDTH-1:0] diff_shadow;
    assign abort_hit = Abort && (state == LOAD || state == SHIFT);
`else
    assign abort_hit = 1'b0;
`endif

    assign diff_nxt = {SerialD, diff[WIDTH-1:1]};
    assign last_bit = (bit_cnt == LAST);

    always_ff @(posedge CLK or posedge R) begin
        if (R) state <= IDLE;
        else   state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (St) state_nxt = LOAD;
            LOAD:  state_nxt = SHIFT;
            SHIFT: if (last_bit) state_nxt = DONE;
            DONE:  state_nxt = St ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_hit) state_nxt = IDLE;
    end

    always_comb begin
        LE     = (state == LOAD);
        BR     = (state == LOAD);
        ShiftE = (state == SHIFT);
        Busy   = (state == LOAD) || (state == SHIFT);
        Done   = (state == DONE);
        PoutE  = (state == DONE);
    end

    // Flags are computed from the final shifted-in bit so they are valid in DONE.
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            bit_cnt <= '0;
            diff    <= '0;
            x_msb   <= 1'b0;
            y_msb   <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
`ifdef SERIAL_SUB_ABORT_EN
            diff_shadow <= '0;
`endif
        end else if (abort_hit) begin
            bit_cnt <= '0;
`ifdef SERIAL_SUB_ABORT_EN
            diff    <= diff_shadow;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (St) begin
`ifdef SERIAL_SUB_ABORT_EN
                        diff_shadow <= diff;
`endif
                        diff    <= '0;
                        bit_cnt <= '0;
                    end
                end
                LOAD: begin
                    x_msb   <= XMsb;
                    y_msb   <= YMsb;
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    diff <= diff_nxt;
                    if (last_bit) begin
                        bit_cnt <= '0;
                        z_q     <= (diff_nxt == '0);
                        n_q     <= BorrowIn;
                        v_q     <= (x_msb ^ y_msb) & (x_msb ^ SerialD);
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign BitCnt     = bit_cnt;
    assign Difference = diff;
    assign Z          = z_q;
    assign N          = n_q;
    assign V          = v_q;

endmodule

// File: tb/tb_serial_sub_sequencer.sv
// Self-checking bench: behavioural serial subtractor datapath around the sequencer,
// results compared against arithmetic subtraction.
module tb_serial_sub_sequencer;

    localparam int W  = 8;
    localparam int CW = $clog2(W);

    logic          CLK = 1'b0;
    logic          R;
    logic          St;
    logic          SerialD, BorrowIn, XMsb, YMsb;
    logic          LE, ShiftE, BR, PoutE, Busy, Done;
    logic [CW-1:0] BitCnt;
    logic [W-1:0]  Difference;
    logic          Z, N, V;
`ifdef SERIAL_SUB_ABORT_EN
    logic          Abort;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] xa, ya;
    logic [W-1:0] xs, ys;
    logic         b;

    serial_sub_sequencer #(.WIDTH(W)) dut (
        .CLK(CLK), .R(R), .St(St),
`ifdef SERIAL_SUB_ABORT_EN
        .Abort(Abort),
`endif
        .SerialD(SerialD), .BorrowIn(BorrowIn), .XMsb(XMsb), .YMsb(YMsb),
        .LE(LE), .ShiftE(ShiftE), .BR(BR), .PoutE(PoutE), .Busy(Busy), .Done(Done),
        .BitCnt(BitCnt), .Difference(Difference), .Z(Z), .N(N), .V(V)
    );

    always #5 CLK = ~CLK;

    // Behavioural datapath: two right-shift registers, borrow flop, full subtractor.
    assign SerialD  = xs[0] ^ ys[0] ^ b;
    assign BorrowIn = (~xs[0] & ys[0]) | (~(xs[0] ^ ys[0]) & b);
    assign XMsb     = xa[W-1];
    assign YMsb     = ya[W-1];

    always @(posedge CLK or posedge R) begin
        if (R) begin
            xs <= '0;
            ys <= '0;
            b  <= 1'b0;
        end else begin
            if (LE) begin
                xs <= xa;
                ys <= ya;
            end else if (ShiftE) begin
                xs <= xs >> 1;
                ys <= ys >> 1;
            end
            if (BR)          b <= 1'b0;
            else if (ShiftE) b <= BorrowIn;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: {diff, Z, N, V} from plain integer arithmetic.
    function automatic logic [W+2:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        int sx, sy, r;
        logic [W-1:0] d;
        logic z, n, v;
        d  = x - y;
        n  = (x < y);
        z  = (d == '0);
        sx = int'($signed(x));
        sy = int'($signed(y));
        r  = sx - sy;
        v  = (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
        return {d, z, n, v};
    endfunction

    task automatic check_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W+2:0] e;
        e = ref_sub(x, y);
        chk({tag, "_diff"}, 32'(Difference), 32'(e[W+2:3]));
        chk({tag, "_z"}, 32'(Z), 32'(e[2]));
        chk({tag, "_n"}, 32'(N), 32'(e[1]));
        chk({tag, "_v"}, 32'(V), 32'(e[0]));
    endtask

    // Counts edges after the St-sampling edge until Done; optionally checks flags held.
    task automatic wait_done(input bit hold, input logic [2:0] hf,
                             output int lat, output int le_n, output int sh_n);
        lat  = -1;
        le_n = 0;
        sh_n = 0;
        for (int i = 1; i <= 4 * W; i++) begin
            if (LE)     le_n++;
            if (ShiftE) sh_n++;
            @(posedge CLK);
            #1;
            if (Done) begin
                lat = i;
                break;
            end
            if (hold) chk("flag_hold", 32'({Z, N, V}), 32'(hf));
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
        int lat, le_n, sh_n;
        xa = x;
        ya = y;
        @(negedge CLK);
        St = 1'b1;
        @(posedge CLK);
        #1;
        St = 1'b0;
        wait_done(1'b0, 3'b000, lat, le_n, sh_n);
        chk({tag, "_latency"}, 32'(lat), 32'(W + 1));
        check_result(tag, x, y);
        chk({tag, "_le_cycles"}, 32'(le_n), 32'd1);
        chk({tag, "_shift_cycles"}, 32'(sh_n), 32'(W));
        chk({tag, "_pout_busy"}, 32'({PoutE, Busy}), 32'b10);
        @(posedge CLK);
        #1;
        chk({tag, "_done_pulse"}, 32'(Done), 32'd0);
    endtask

    initial begin
        int lat, le_n, sh_n;
        logic [2:0] held;
        R  = 1'b1;
        St = 1'b0;
        xa = '0;
        ya = '0;
`ifdef SERIAL_SUB_ABORT_EN
        Abort = 1'b0;
`endif
        #1;
        chk("reset_outputs", 32'({LE, ShiftE, BR, PoutE, Busy, Done, BitCnt, Difference, Z, N, V}), 32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        R = 1'b0;

        run_op("nominal", 8'h34, 8'hF7);
        run_op("zero", 8'h55, 8'h55);
        run_op("ovf_neg", 8'h80, 8'h01);
        run_op("ovf_pos", 8'h7F, 8'hFF);

        // Asynchronous reset in the middle of SHIFT.
        xa = 8'hA5;
        ya = 8'h3C;
        @(negedge CLK);
        St = 1'b1;
        @(posedge CLK);
        #1;
        St = 1'b0;
        for (int i = 0; i < 4 * W; i++) begin
            if (BitCnt == CW'(3)) break;
            @(posedge CLK);
            #1;
        end
        chk("rst_at_bitcnt3", 32'(BitCnt), 32'd3);
        #2;
        R = 1'b1;
        #1;
        chk("rst_mid_outputs", 32'({LE, ShiftE, BR, PoutE, Busy, Done, BitCnt, Difference, Z, N, V}), 32'd0);
        @(negedge CLK);
        R = 1'b0;
        run_op("after_rst", 8'h34, 8'hF7);

        // Back-to-back: St held through DONE.
        xa = 8'h7F;
        ya = 8'hFF;
        @(negedge CLK);
        St = 1'b1;
        @(posedge CLK);
        #1;
        wait_done(1'b0, 3'b000, lat, le_n, sh_n);
        chk("b2b_first_latency", 32'(lat), 32'(W + 1));
        check_result("b2b_first", 8'h7F, 8'hFF);
        held = {Z, N, V};
        xa = 8'h10;
        ya = 8'h01;
        @(posedge CLK);
        #1;
        St = 1'b0;
        chk("b2b_load_follows_done", 32'({LE, Done}), 32'b10);
        chk("b2b_flags_in_load", 32'({Z, N, V}), 32'(held));
        wait_done(1'b1, held, lat, le_n, sh_n);
        chk("b2b_second_latency", 32'(lat), 32'(W + 1));
        check_result("b2b_second", 8'h10, 8'h01);

        for (int k = 0; k < 16; k++) begin
            run_op("rand", W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
        end

`ifdef SERIAL_SUB_ABORT_EN
        run_op("pre_abort", 8'h34, 8'hF7);
        held = {Z, N, V};
        xa = 8'h12;
        ya = 8'h34;
        @(negedge CLK);
        St = 1'b1;
        @(posedge CLK);
        #1;
        St = 1'b0;
        for (int i = 0; i < 4 * W; i++) begin
            if (BitCnt == CW'(4)) break;
            @(posedge CLK);
            #1;
        end
        chk("abort_at_bitcnt4", 32'(BitCnt), 32'd4);
        @(negedge CLK);
        Abort = 1'b1;
        @(posedge CLK);
        #1;
        Abort = 1'b0;
        chk("abort_idle", 32'({Busy, ShiftE, LE}), 32'd0);
        chk("abort_diff_restored", 32'(Difference), 32'h3D);
        chk("abort_flags_kept", 32'({Z, N, V}), 32'(held));
        lat = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge CLK);
            #1;
            if (Done) lat++;
        end
        chk("abort_no_done", 32'(lat), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
